// File: rtl/vreg_pkg.sv
// Shared definitions for the vector-register write arbiter.
//   VREG_DATA_W / VREG_ADDR_W / VREG_NUM : default register width, address width, register count
//   req_id_t                             : requester identity, also used as the round-robin pointer
//   IDX_MEM / IDX_ALU                    : bit positions of each requester in req/gnt vectors
package vreg_pkg;
    localparam int VREG_DATA_W = 256;
    localparam int VREG_ADDR_W = 5;
    localparam int VREG_NUM    = 32;

    typedef enum logic {
        REQ_MEM = 1'b0,
        REQ_ALU = 1'b1
    } req_id_t;

    localparam int IDX_MEM = 0;
    localparam int IDX_ALU = 1;
endpackage

// File: rtl/vreg_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter (module rr_arb2).
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, bit IDX_MEM = load unit, bit IDX_ALU = vector ALU
//   gnt[1:0]   : one-hot grant, combinational from req and the internal pointer
// The pointer names the requester that wins a tie; it moves to the other
// requester after every grant and sits at REQ_MEM out of reset.
module rr_arb2
    import vreg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_t prio;

    always_comb begin
        gnt = 2'b00;
        if (req[IDX_MEM] && (!req[IDX_ALU] || prio == REQ_MEM)) begin
            gnt[IDX_MEM] = 1'b1;
        end else if (req[IDX_ALU]) begin
            gnt[IDX_ALU] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= REQ_MEM;
        end else if (gnt[IDX_MEM]) begin
            prio <= REQ_ALU;
        end else if (gnt[IDX_ALU]) begin
            prio <= REQ_MEM;
        end
    end

endmodule

// File: rtl/vreg_write_arbiter.sv
// Vector register-file write-port arbiter with optional destination scoreboard.
// Build option: define VREG_SCOREBOARD_EN to compile in the pending-write scoreboard;
// without it busy and hazard are tied low and rsv_* / chk_* are ignored.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data       : vector-ALU writeback request, alu_ready = accepted
//   mem_valid/mem_rd/mem_data       : vector-load writeback request, mem_ready = accepted
//   WriteEn/rd/InputData            : registered register-file write port (latency 1)
//   rsv_en/rsv_rd                   : issue-stage destination reservation
//   chk_rs1/chk_rs2/chk_rd          : issue-stage operands to hazard-check
//   hazard                          : any checked register has a pending write
//   busy                            : pending-write vector, one bit per register
module vreg_write_arbiter
    import vreg_pkg::*;
#(
    parameter int DATA_W = VREG_DATA_W,
    parameter int ADDR_W = VREG_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    output logic                WriteEn,
    output logic [ADDR_W-1:0]   rd,
    output logic [DATA_W-1:0]   InputData,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_rd,
    input  logic [ADDR_W-1:0]   chk_rs1,
    input  logic [ADDR_W-1:0]   chk_rs2,
    input  logic [ADDR_W-1:0]   chk_rd,
    output logic                hazard,
    output logic [VREG_NUM-1:0] busy
);

    logic [1:0]        gnt_p0;
    logic [ADDR_W-1:0] sel_rd_p0;
    logic [DATA_W-1:0] sel_data_p0;

    logic              we_p1;
    logic [ADDR_W-1:0] rd_p1;
    logic [DATA_W-1:0] data_p1;

    // Stage p0: arbitration and source select
    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({alu_valid, mem_valid}),
        .gnt   (gnt_p0)
    );

    assign mem_ready = gnt_p0[IDX_MEM];
    assign alu_ready = gnt_p0[IDX_ALU];

    always_comb begin
        sel_rd_p0   = mem_rd;
        sel_data_p0 = mem_data;
        if (gnt_p0[IDX_ALU]) begin
            sel_rd_p0   = alu_rd;
            sel_data_p0 = alu_data;
        end
    end

    // Stage p1: registered write port; address/data hold when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_p1   <= 1'b0;
            rd_p1   <= '0;
            data_p1 <= '0;
        end else begin
            we_p1 <= |gnt_p0;
            if (|gnt_p0) begin
                rd_p1   <= sel_rd_p0;
                data_p1 <= sel_data_p0;
            end
        end
    end

    assign WriteEn   = we_p1;
    assign rd        = rd_p1;
    assign InputData = data_p1;

`ifdef VREG_SCOREBOARD_EN
    logic [VREG_NUM-1:0] busy_q;
    logic [VREG_NUM-1:0] busy_nxt;

    // Clear for the write being committed, then set for the new reservation,
    // so a same-cycle set and clear of one register leaves it busy.
    always_comb begin
        busy_nxt = busy_q;
        if (we_p1) begin
            busy_nxt[rd_p1] = 1'b0;
        end
        if (rsv_en) begin
            busy_nxt[rsv_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy   = busy_q;
    assign hazard = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{rsv_en, rsv_rd, chk_rs1, chk_rs2, chk_rd};
    assign busy   = '0;
    assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_vreg_write_arbiter.sv
// Bench for vreg_write_arbiter: directed scenarios followed by random traffic,
// all checked against a behavioural model of arbitration, write port and scoreboard.
module tb_vreg_write_arbiter;
    import vreg_pkg::*;

    localparam int DW = VREG_DATA_W;
    localparam int AW = VREG_ADDR_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, mem_valid;
    logic [AW-1:0] alu_rd, mem_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          WriteEn;
    logic [AW-1:0] rd;
    logic [DW-1:0] InputData;
    logic          rsv_en;
    logic [AW-1:0] rsv_rd, chk_rs1, chk_rs2, chk_rd;
    logic          hazard;
    logic [31:0]   busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: who was granted last, what the write port shows,
    // and which registers have an outstanding reservation.
    req_id_t     m_last;
    bit          m_we;
    bit [AW-1:0] m_rd;
    bit [DW-1:0] m_data;
    bit [31:0]   m_busy;
`ifdef VREG_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    always #5 clk = ~clk;

    vreg_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .WriteEn(WriteEn), .rd(rd), .InputData(InputData),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard), .busy(busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [DW-1:0] rnd_data();
        bit [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        m_last = REQ_ALU;   // mem is favoured after reset
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
        m_busy = '0;
    endtask

    function automatic bit exp_hazard();
        if (!SB) return 1'b0;
        return m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd];
    endfunction

    // One clock: check the combinational outputs before the edge, advance the
    // model with the current inputs, then check the registered outputs after it.
    task automatic tick(output bit ga, output bit gm);
        bit [31:0] nb;
        @(negedge clk);
        gm = mem_valid && (!alu_valid || m_last == REQ_ALU);
        ga = alu_valid && !gm;
        chk("alu_ready", alu_ready, ga);
        chk("mem_ready", mem_ready, gm);
        chk("hazard", hazard, exp_hazard());
        nb = m_busy;
        if (m_we) nb[m_rd] = 1'b0;
        if (rsv_en) nb[rsv_rd] = 1'b1;
        if (!SB) nb = '0;
        @(posedge clk);
        #1;
        m_we = ga | gm;
        if (gm) begin m_rd = mem_rd; m_data = mem_data; m_last = REQ_MEM; end
        if (ga) begin m_rd = alu_rd; m_data = alu_data; m_last = REQ_ALU; end
        m_busy = nb;
        chk("WriteEn", WriteEn, m_we);
        chk("rd", rd, m_rd);
        chk("InputData", InputData, m_data);
        chk("busy", busy, m_busy);
    endtask

    initial begin
        bit ga, gm;
        bit [DW-1:0] aa;
        rst_n = 1'b0;
        alu_valid = 0; mem_valid = 0; alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;
        rsv_en = 0; rsv_rd = 0; chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
        model_reset();
        repeat (3) @(posedge clk);

        // Reset state, and arbitration from the reset pointer
        @(negedge clk);
        alu_valid = 1; mem_valid = 1;
        #1;
        chk("rst_WriteEn", WriteEn, 1'b0);
        chk("rst_rd", rd, '0);
        chk("rst_InputData", InputData, '0);
        chk("rst_busy", busy, '0);
        chk("rst_mem_ready", mem_ready, 1'b1);
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_hazard", hazard, 1'b0);
        alu_valid = 0; mem_valid = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single ALU request after reset
        for (int i = 0; i < DW / 8; i++) aa[i*8 +: 8] = 8'hAA;
        alu_valid = 1; alu_rd = 3; alu_data = aa;
        tick(ga, gm);
        chk("s1_rd3", rd, 5'd3);
        chk("s1_dataAA", InputData, aa);
        alu_valid = 0;
        tick(ga, gm);

        // Both valid for four cycles: alternating mem, alu, mem, alu with no bubbles
        alu_valid = 1; mem_valid = 1; alu_rd = 1; mem_rd = 2;
        for (int i = 0; i < 4; i++) begin
            alu_data = rnd_data(); mem_data = rnd_data();
            tick(ga, gm);
            chk("s2_order", {ga, gm}, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("s2_we", WriteEn, 1'b1);
        end
        alu_valid = 0; mem_valid = 0;
        tick(ga, gm);

        // Same destination: mem first, alu's data persists
        alu_valid = 1; mem_valid = 1; alu_rd = 7; mem_rd = 7; alu_data = 1; mem_data = 2;
        tick(ga, gm);
        chk("s3_first", InputData, 2);
        mem_valid = 0;
        tick(ga, gm);
        alu_valid = 0;
        tick(ga, gm);
        chk("s3_final_rd", rd, 5'd7);
        chk("s3_final", InputData, 1);

        // Reservation of v5, hazard on rs1, cleared by the load writeback
        rsv_en = 1; rsv_rd = 5; chk_rs1 = 5; chk_rs2 = 0; chk_rd = 0;
        tick(ga, gm);                       // cycle 0
        rsv_en = 0;
        tick(ga, gm);                       // cycle 1
        tick(ga, gm);                       // cycle 2
        mem_valid = 1; mem_rd = 5; mem_data = rnd_data();
        tick(ga, gm);                       // cycle 3: accept
        mem_valid = 0;
        chk("s4_hz_c4", hazard, SB);
        tick(ga, gm);                       // cycle 4: WriteEn
        chk("s4_busy5", busy[5], 1'b0);
        tick(ga, gm);                       // cycle 5
        chk("s4_hz_c6", hazard, 1'b0);

        // Same-cycle set and clear of v9: set wins
        mem_valid = 1; mem_rd = 9; mem_data = rnd_data();
        tick(ga, gm);
        mem_valid = 0; rsv_en = 1; rsv_rd = 9;
        tick(ga, gm);
        rsv_en = 0; chk_rs1 = 9;
        chk("s5_busy9", busy[9], SB);
        tick(ga, gm);

        // Random traffic; a loser keeps its request until accepted
        for (int n = 0; n < 300; n++) begin
            bit hold_a, hold_m;
            hold_a = alu_valid && !ga;
            hold_m = mem_valid && !gm;
            if (!hold_a) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd = AW'($urandom); alu_data = rnd_data();
            end
            if (!hold_m) begin
                mem_valid = ($urandom_range(0, 2) != 0);
                mem_rd = AW'($urandom); mem_data = rnd_data();
            end
            rsv_en = ($urandom_range(0, 3) == 0); rsv_rd = AW'($urandom);
            chk_rs1 = AW'($urandom); chk_rs2 = AW'($urandom); chk_rd = AW'($urandom);
            tick(ga, gm);
        end
        alu_valid = 0; mem_valid = 0; rsv_en = 0;
        tick(ga, gm);

        // Reset the cycle after an accept: pending write and reservations dropped
        alu_valid = 1; alu_rd = 4; alu_data = rnd_data(); rsv_en = 1; rsv_rd = 12;
        tick(ga, gm);
        alu_valid = 0; rsv_en = 0;
        chk("s6_pre_we", WriteEn, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("s6_we", WriteEn, 1'b0);
        chk("s6_busy", busy, '0);
        chk("s6_rd", rd, '0);
        chk("s6_data", InputData, '0);
        chk("s6_hazard", hazard, 1'b0);
        alu_valid = 1; mem_valid = 1;
        #1;
        chk("s6_mem_ready", mem_ready, 1'b1);
        chk("s6_alu_ready", alu_ready, 1'b0);
        alu_valid = 0; mem_valid = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        alu_valid = 1; mem_valid = 1; alu_rd = 6; mem_rd = 8;
        alu_data = rnd_data(); mem_data = rnd_data();
        tick(ga, gm);
        chk("s6_post_mem", gm, 1'b1);
        alu_valid = 0; mem_valid = 0;
        tick(ga, gm);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vreg_write_arbiter.md
VREG_WRITE_ARBITER -- requirements
Module: vreg_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 256, giving the vector register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the register address width (32 registers).
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-005 Ports alu_valid (in, 1), alu_rd (in, ADDR_W) and alu_data (in, DATA_W) SHALL form the vector-ALU writeback request.
REQ-006 Port alu_ready SHALL be an output, 1 bit wide: ALU request accepted this cycle.
REQ-007 Ports mem_valid (in, 1), mem_rd (in, ADDR_W) and mem_data (in, DATA_W) SHALL form the vector-load writeback request.
REQ-008 Port mem_ready SHALL be an output, 1 bit wide: load request accepted this cycle.
REQ-009 Ports WriteEn (out, 1), rd (out, ADDR_W) and InputData (out, DATA_W) SHALL drive the register-file write port.
REQ-010 Ports rsv_en (in, 1) and rsv_rd (in, ADDR_W) SHALL carry the issue-stage destination reservation.
REQ-011 Ports chk_rs1, chk_rs2 and chk_rd (in, ADDR_W each) SHALL carry the issue-stage operands to be hazard-checked.
REQ-012 Port hazard SHALL be an output, 1 bit wide: asserted when any checked register is busy.
REQ-013 Port busy SHALL be an output, 32 bits wide: the scoreboard pending-write vector.

Function
REQ-014 A request SHALL be accepted in a cycle when valid and ready are both high; ready SHALL be a combinational function of both valid inputs and the priority pointer only.
REQ-015 With exactly one valid requester, that requester SHALL get ready=1.
REQ-016 With both requesters valid, the requester not granted most recently SHALL win (round-robin), and the loser's ready SHALL be 0.
REQ-017 The priority pointer SHALL update only on a grant; after reset it SHALL favour mem.
REQ-018 An accepted request SHALL appear on WriteEn=1/rd/InputData exactly one cycle later (registered output, latency 1).
REQ-019 With no grant, WriteEn SHALL be 0 next cycle; rd and InputData SHALL hold their previous values.
REQ-020 Throughput SHALL be one write per cycle, with no bubbles under continuous requests.
REQ-021 A requester held off by arbitration SHALL keep valid, rd and data stable until accepted; the block does not buffer losers.
REQ-022 Two requests to the same rd SHALL be written in grant order, so the later grant's data persists.

Reset
REQ-023 While rst_n=0: WriteEn=0, rd=0, InputData=0, busy=0, and the pointer favours mem; ready outputs SHALL follow REQ-015/016 from that state.
REQ-024 Reset asserted mid-operation SHALL drop any registered, uncommitted write (WriteEn=0 immediately) and clear all reservations.

Configuration
REQ-025 Macro VREG_SCOREBOARD_EN SHALL compile in the scoreboard.
REQ-026 With the macro defined:
- rsv_en=1 sets busy[rsv_rd] at the next edge.
- A cycle with WriteEn=1 clears busy[rd] at the next edge.
- A set and a clear of the same register in the same cycle: set wins.
- hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd], combinational.
REQ-027 Without the macro, busy SHALL be tied to 0, hazard SHALL be tied to 0, and the rsv_* and chk_* inputs SHALL be ignored.

Structure
REQ-028 Package vreg_pkg SHALL hold VREG_DATA_W=256, VREG_ADDR_W=5, VREG_NUM=32 and the enum req_id_t {REQ_MEM, REQ_ALU}.
REQ-029 The round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], clk, rst_n; output gnt[1:0]; pointer state internal).

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- After reset: alu_valid=1, rd=3, data=0xAA..AA, mem idle -> alu_ready=1; next cycle WriteEn=1, rd=3, InputData=0xAA..AA.
- Both valid for 4 cycles (alu rd=1, mem rd=2) -> grants mem, alu, mem, alu; WriteEn high for 4 consecutive cycles.
- Both valid with the same rd=7 (alu data=1, mem data=2), mem first -> writes 2 then 1; final value 1.
- rsv_rd=5 at cycle 0; chk_rs1=5 -> hazard=1 from cycle 1; mem write rd=5 accepted at cycle 3 -> WriteEn at cycle 4, busy[5]=0 and hazard=0 at cycle 5.
- rsv_rd=9 in the same cycle as WriteEn with rd=9 -> busy[9]=1 afterwards.
- rst_n low the cycle after an accept -> WriteEn=0 immediately, busy=0; without VREG_SCOREBOARD_EN, hazard stays 0 throughout.
